// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the ID/EX/MEM pipeline stages and the hazard stall controller.
// The pipeline drives the stage fields (master); the controller returns the stall/flush controls (slave).
interface hazard_stall_ctrl_if;
   logic [4:0]  Rs_ID;
   logic [4:0]  Rt_ID;
   logic        UseRs_ID;
   logic        UseRt_ID;
   logic        BranchRs_ID;
   logic        BranchRt_ID;
   logic        Taken_ID;
   logic        HiLoUse_ID;
   logic [4:0]  RegAddr_EX;
   logic        RegWrite_EX;
   logic        MemRead_EX;
   logic [4:0]  RegAddr_MEM;
   logic        MemRead_MEM;
   logic        MulStart_EX;
   logic        DivStart_EX;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        IDEXBubble;
   logic        IFIDFlush;
   logic        MDBusy;
   logic        MDDone;
   logic [31:0] StallCount;

   modport master (
      output Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, BranchRs_ID, BranchRt_ID, Taken_ID,
             HiLoUse_ID, RegAddr_EX, RegWrite_EX, MemRead_EX, RegAddr_MEM, MemRead_MEM,
             MulStart_EX, DivStart_EX,
      input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDBusy, MDDone, StallCount
   );

   modport slave (
      input  Rs_ID, Rt_ID, UseRs_ID, UseRt_ID, BranchRs_ID, BranchRt_ID, Taken_ID,
             HiLoUse_ID, RegAddr_EX, RegWrite_EX, MemRead_EX, RegAddr_MEM, MemRead_MEM,
             MulStart_EX, DivStart_EX,
      output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, MDBusy, MDDone, StallCount
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS core: load-use, branch-operand and HI/LO
// occupancy stalls, taken-branch flush, mult/div busy tracking and a stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic                clk,
   input  logic                reset,
   hazard_stall_ctrl_if.slave  pipe
);

   typedef enum logic {IDLE, BUSY} mdState_e;

   mdState_e          mdState;
   logic [CNT_W-1:0]  mdCnt;
   logic [31:0]       stallCnt;

   logic exNonZero, memNonZero;
   logic rsHitEx, rtHitEx, rsHitMem, rtHitMem;
   logic loadUse, brHaz, mdHaz, stall;
   logic busy, done, mdStart;

   assign exNonZero  = (pipe.RegAddr_EX  != 5'd0);
   assign memNonZero = (pipe.RegAddr_MEM != 5'd0);
   assign rsHitEx    = exNonZero  && (pipe.Rs_ID == pipe.RegAddr_EX);
   assign rtHitEx    = exNonZero  && (pipe.Rt_ID == pipe.RegAddr_EX);
   assign rsHitMem   = memNonZero && (pipe.Rs_ID == pipe.RegAddr_MEM);
   assign rtHitMem   = memNonZero && (pipe.Rt_ID == pipe.RegAddr_MEM);

   assign loadUse = pipe.MemRead_EX && pipe.RegWrite_EX &&
                    ((pipe.UseRs_ID && rsHitEx) || (pipe.UseRt_ID && rtHitEx));

   // Branches resolve in ID, so a load still in EX or MEM cannot be forwarded in time.
   assign brHaz = (pipe.MemRead_EX  && ((pipe.BranchRs_ID && rsHitEx)  || (pipe.BranchRt_ID && rtHitEx))) ||
                  (pipe.MemRead_MEM && ((pipe.BranchRs_ID && rsHitMem) || (pipe.BranchRt_ID && rtHitMem)));

   assign busy    = (mdState == BUSY);
   assign done    = busy && (mdCnt == '0);
   assign mdHaz   = pipe.HiLoUse_ID && busy && !done;
   assign mdStart = pipe.MulStart_EX || pipe.DivStart_EX;

   assign stall = !reset && (loadUse || brHaz || mdHaz);

   assign pipe.PCWrite    = !stall;
   assign pipe.IFIDWrite  = !stall;
   assign pipe.IDEXBubble = stall;
   // A stalled branch may have been resolved from stale operands, so it must not flush.
   assign pipe.IFIDFlush  = !reset && pipe.Taken_ID && !stall;
   assign pipe.MDBusy     = !reset && busy;
   assign pipe.MDDone     = !reset && done;
   assign pipe.StallCount = stallCnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         mdState  <= IDLE;
         mdCnt    <= '0;
         stallCnt <= '0;
      end else begin
         if (stall)
            stallCnt <= stallCnt + 32'd1;

         case (mdState)
            IDLE: begin
               if (pipe.DivStart_EX) begin
                  mdState <= BUSY;
                  mdCnt   <= CNT_W'(DIV_LAT - 1);
               end else if (pipe.MulStart_EX) begin
                  mdState <= BUSY;
                  mdCnt   <= CNT_W'(MUL_LAT - 1);
               end
            end
            BUSY: begin
               if (mdCnt == '0) begin
                  // Back-to-back issue in the done cycle reloads without passing through IDLE.
                  if (pipe.DivStart_EX)
                     mdCnt <= CNT_W'(DIV_LAT - 1);
                  else if (pipe.MulStart_EX)
                     mdCnt <= CNT_W'(MUL_LAT - 1);
                  mdState <= mdStart ? BUSY : IDLE;
               end else begin
                  mdCnt <= mdCnt - CNT_W'(1);
               end
            end
            default: mdState <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MUL_LAT=4, DIV_LAT=32: inputs change on the
// falling edge and outputs are sampled 1 ns later, away from the rising edge.
module tb_hazard_stall_ctrl;

   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] expCount;

   hazard_stall_ctrl_if bus ();

   hazard_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .pipe  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A mult/div issue while the unit is still busy must never reach EX.
   always @(posedge clk) begin
      if (!reset && bus.MDBusy && !bus.MDDone && (bus.MulStart_EX || bus.DivStart_EX)) begin
         errors++;
         $display("FAIL md_protocol: start issued while busy at %0t", $time);
      end
   end

   task automatic clear_inputs();
      bus.Rs_ID = 5'd0;       bus.Rt_ID = 5'd0;
      bus.UseRs_ID = 1'b0;    bus.UseRt_ID = 1'b0;
      bus.BranchRs_ID = 1'b0; bus.BranchRt_ID = 1'b0;
      bus.Taken_ID = 1'b0;    bus.HiLoUse_ID = 1'b0;
      bus.RegAddr_EX = 5'd0;  bus.RegWrite_EX = 1'b0; bus.MemRead_EX = 1'b0;
      bus.RegAddr_MEM = 5'd0; bus.MemRead_MEM = 1'b0;
      bus.MulStart_EX = 1'b0; bus.DivStart_EX = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      @(negedge clk);
      // Hazard inputs present while in reset must not stall.
      bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd3;
      bus.UseRs_ID = 1'b1;   bus.Rs_ID = 5'd3;       bus.Taken_ID = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL reset_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.IFIDWrite !== 1'b1) begin errors++; $display("FAIL reset_ifidwrite: got %b want 1", bus.IFIDWrite); end
      checks++; if (bus.IDEXBubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", bus.IDEXBubble); end
      checks++; if (bus.IFIDFlush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.IFIDFlush); end
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL reset_mdbusy: got %b want 0", bus.MDBusy); end
      checks++; if (bus.MDDone !== 1'b0) begin errors++; $display("FAIL reset_mddone: got %b want 0", bus.MDDone); end
      checks++; if (bus.StallCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.StallCount); end
      @(negedge clk);
      reset = 1'b0;
      clear_inputs();
      expCount = 32'd0;
   endtask

   task automatic test_reg_zero();
      @(negedge clk);
      clear_inputs();
      bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd0;
      bus.UseRs_ID = 1'b1;   bus.UseRt_ID = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL zero_loaduse_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.IDEXBubble !== 1'b0) begin errors++; $display("FAIL zero_loaduse_bubble: got %b want 0", bus.IDEXBubble); end
      @(negedge clk);
      clear_inputs();
      bus.MemRead_MEM = 1'b1; bus.RegAddr_MEM = 5'd0; bus.BranchRs_ID = 1'b1; bus.BranchRt_ID = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL zero_branch_pcwrite: got %b want 1", bus.PCWrite); end
      @(negedge clk);
      clear_inputs();
      // Register matches but the ID instruction does not read it.
      bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd5; bus.Rs_ID = 5'd5;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL unused_rs_pcwrite: got %b want 1", bus.PCWrite); end
      @(negedge clk);
      clear_inputs();
      #1;
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL zero_count: got %0d want %0d", bus.StallCount, expCount); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      clear_inputs();
      bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd3;
      bus.UseRs_ID = 1'b1;   bus.Rs_ID = 5'd3;       bus.UseRt_ID = 1'b1; bus.Rt_ID = 5'd5;
      #1;
      checks++; if (bus.PCWrite !== 1'b0) begin errors++; $display("FAIL lu_pcwrite: got %b want 0", bus.PCWrite); end
      checks++; if (bus.IFIDWrite !== 1'b0) begin errors++; $display("FAIL lu_ifidwrite: got %b want 0", bus.IFIDWrite); end
      checks++; if (bus.IDEXBubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", bus.IDEXBubble); end
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL lu_count_before: got %0d want %0d", bus.StallCount, expCount); end
      expCount = expCount + 32'd1;
      @(negedge clk);
      // Load has moved to MEM, bubble in EX; add may now proceed via forwarding.
      bus.MemRead_EX = 1'b0; bus.RegWrite_EX = 1'b0; bus.RegAddr_EX = 5'd0;
      bus.MemRead_MEM = 1'b1; bus.RegAddr_MEM = 5'd3;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL lu_next_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.IDEXBubble !== 1'b0) begin errors++; $display("FAIL lu_next_bubble: got %b want 0", bus.IDEXBubble); end
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL lu_count_after: got %0d want %0d", bus.StallCount, expCount); end
      @(negedge clk);
      clear_inputs();
      // Load-use through rt only (sw data or R-type rt).
      bus.MemRead_EX = 1'b1; bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd9;
      bus.UseRs_ID = 1'b1;   bus.Rs_ID = 5'd4;       bus.UseRt_ID = 1'b1; bus.Rt_ID = 5'd9;
      #1;
      checks++; if (bus.IDEXBubble !== 1'b1) begin errors++; $display("FAIL lu_rt_bubble: got %b want 1", bus.IDEXBubble); end
      expCount = expCount + 32'd1;
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_branch();
      @(negedge clk);
      clear_inputs();
      // ALU result in EX is forwarded to the branch comparator: no stall, flush allowed.
      bus.RegWrite_EX = 1'b1; bus.RegAddr_EX = 5'd7;
      bus.BranchRs_ID = 1'b1; bus.BranchRt_ID = 1'b1; bus.Rs_ID = 5'd7; bus.Rt_ID = 5'd2;
      bus.Taken_ID = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL br_alu_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.IFIDFlush !== 1'b1) begin errors++; $display("FAIL br_alu_flush: got %b want 1", bus.IFIDFlush); end
      @(negedge clk);
      bus.MemRead_EX = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b0) begin errors++; $display("FAIL br_c1_pcwrite: got %b want 0", bus.PCWrite); end
      checks++; if (bus.IFIDFlush !== 1'b0) begin errors++; $display("FAIL br_c1_flush: got %b want 0", bus.IFIDFlush); end
      @(negedge clk);
      bus.MemRead_EX = 1'b0; bus.RegWrite_EX = 1'b0; bus.RegAddr_EX = 5'd0;
      bus.MemRead_MEM = 1'b1; bus.RegAddr_MEM = 5'd7;
      #1;
      checks++; if (bus.IDEXBubble !== 1'b1) begin errors++; $display("FAIL br_c2_bubble: got %b want 1", bus.IDEXBubble); end
      checks++; if (bus.IFIDFlush !== 1'b0) begin errors++; $display("FAIL br_c2_flush: got %b want 0", bus.IFIDFlush); end
      @(negedge clk);
      bus.MemRead_MEM = 1'b0; bus.RegAddr_MEM = 5'd0;
      expCount = expCount + 32'd2;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL br_c3_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.IFIDFlush !== 1'b1) begin errors++; $display("FAIL br_c3_flush: got %b want 1", bus.IFIDFlush); end
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL br_count: got %0d want %0d", bus.StallCount, expCount); end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic test_div_stall();
      @(negedge clk);
      clear_inputs();
      bus.DivStart_EX = 1'b1;
      #1;
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL div_issue_busy: got %b want 0", bus.MDBusy); end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         bus.DivStart_EX = 1'b0;
         bus.HiLoUse_ID  = 1'b1;
         #1;
         checks++; if (bus.MDBusy !== 1'b1) begin errors++; $display("FAIL div_busy[%0d]: got %b want 1", k, bus.MDBusy); end
         checks++; if (bus.MDDone !== (k == 32)) begin errors++; $display("FAIL div_done[%0d]: got %b want %b", k, bus.MDDone, (k == 32)); end
         checks++; if (bus.PCWrite !== (k == 32)) begin errors++; $display("FAIL div_pcwrite[%0d]: got %b want %b", k, bus.PCWrite, (k == 32)); end
      end
      expCount = expCount + 32'd31;
      @(negedge clk);
      bus.HiLoUse_ID = 1'b0;
      #1;
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL div_idle: got %b want 0", bus.MDBusy); end
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL div_count: got %0d want %0d", bus.StallCount, expCount); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      clear_inputs();
      bus.MulStart_EX = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bus.MulStart_EX = (k == 4);
         #1;
         checks++; if (bus.MDBusy !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d]: got %b want 1", k, bus.MDBusy); end
         checks++; if (bus.MDDone !== (k == 4 || k == 8)) begin errors++; $display("FAIL b2b_done[%0d]: got %b want %b", k, bus.MDDone, (k == 4 || k == 8)); end
      end
      @(negedge clk);
      bus.MulStart_EX = 1'b0;
      #1;
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.MDBusy); end
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      clear_inputs();
      // Both starts high: div latency must win, so no done at cycle 4.
      bus.MulStart_EX = 1'b1; bus.DivStart_EX = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         bus.MulStart_EX = 1'b0; bus.DivStart_EX = 1'b0;
         #1;
         checks++; if (bus.MDBusy !== 1'b1) begin errors++; $display("FAIL abort_busy[%0d]: got %b want 1", k, bus.MDBusy); end
         checks++; if (bus.MDDone !== 1'b0) begin errors++; $display("FAIL abort_done[%0d]: got %b want 0", k, bus.MDDone); end
      end
      @(negedge clk);
      reset = 1'b1;
      bus.HiLoUse_ID = 1'b1;
      #1;
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL abort_rst_pcwrite: got %b want 1", bus.PCWrite); end
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL abort_rst_busy: got %b want 0", bus.MDBusy); end
      @(negedge clk);
      reset = 1'b0;
      expCount = 32'd0;
      #1;
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", bus.MDBusy); end
      checks++; if (bus.MDDone !== 1'b0) begin errors++; $display("FAIL abort_done_after: got %b want 0", bus.MDDone); end
      checks++; if (bus.StallCount !== expCount) begin errors++; $display("FAIL abort_count: got %0d want %0d", bus.StallCount, expCount); end
      checks++; if (bus.PCWrite !== 1'b1) begin errors++; $display("FAIL abort_pcwrite: got %b want 1", bus.PCWrite); end
      @(negedge clk);
      #1;
      checks++; if (bus.MDBusy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b want 0", bus.MDBusy); end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_reg_zero();
      test_load_use();
      test_branch();
      test_div_stall();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
